// File: rtl/oam_dma.sv
// sm83_pkg: shared SM83 bus types.
//   addr_t - 16-bit bus address
//   data_t - 8-bit bus data
//
// oam_dma: OAM DMA engine. It copies LEN bytes from the source page {src_page_i, 8'h00}
// to DST_BASE. After a one-cycle DELAY, each XFER cycle reads one byte and writes the byte
// read in the previous cycle. A final FLUSH cycle writes the last byte and pulses done_o.
// busy_o is high for exactly LEN+2 cycles.
//
// Ports:
//   clk_i          clock; all state changes on the rising edge
//   rst_i          asynchronous active-high reset
//   start_i        one-cycle transfer request; a request while busy restarts the transfer
//   src_page_i     source page, latched when start_i is accepted
//   busy_o         transfer in progress (DELAY, XFER, FLUSH)
//   done_o         one-cycle pulse in the final write cycle
//   mem_r_addr_o   read address; mem_r_data_i returns the byte in the same cycle
//   mem_r_data_i   read data
//   mem_wen_o      write enable; memory writes on the rising edge while high
//   mem_w_addr_o   write address
//   mem_w_data_o   write data
package sm83_pkg;
    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;
endpackage

module oam_dma
    import sm83_pkg::*;
#(
    parameter int unsigned LEN      = 160,
    parameter addr_t       DST_BASE = 16'hFE00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  src_page_i,
    output logic        busy_o,
    output logic        done_o,
    output addr_t       mem_r_addr_o,
    input  data_t       mem_r_data_i,
    output logic        mem_wen_o,
    output addr_t       mem_w_addr_o,
    output data_t       mem_w_data_o
);

    typedef enum logic [1:0] {StIdle, StDelay, StXfer, StFlush} state_e;

    // 9-bit index so that LEN=256 still reaches its terminal value.
    localparam logic [8:0] LastIdx   = 9'(LEN - 1);
    localparam addr_t      FlushAddr = DST_BASE + 16'(LEN - 1);

    state_e      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    data_t       rdata_q, rdata_d;

    logic        busy_d, done_d, wen_d;
    addr_t       r_addr_d, w_addr_d;
    data_t       w_data_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StDelay;
                    page_d  = src_page_i;
                    idx_d   = '0;
                end
            end
            StDelay: begin
                state_d = StXfer;
                idx_d   = '0;
            end
            StXfer: begin
                rdata_d = mem_r_data_i;
                idx_d   = idx_q + 9'd1;
                if (idx_q == LastIdx) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase

        // A request while busy restarts from DELAY. The byte captured on this edge is
        // overwritten before any write of the new transfer uses it.
        if (start_i && (state_q != StIdle)) begin
            state_d = StDelay;
            page_d  = src_page_i;
            idx_d   = '0;
        end

        // Outputs are registered: decode them from the next state so that they line up
        // with the state they belong to.
        busy_d   = 1'b0;
        done_d   = 1'b0;
        wen_d    = 1'b0;
        r_addr_d = '0;
        w_addr_d = '0;
        w_data_d = '0;
        unique case (state_d)
            StIdle: begin
            end
            StDelay: begin
                busy_d = 1'b1;
            end
            StXfer: begin
                busy_d   = 1'b1;
                // idx_d <= 255 here, so the add never carries out of the page.
                r_addr_d = {page_d, 8'h00} + 16'(idx_d);
                // idx 0 only primes rdata_q; the first write happens at idx 1.
                wen_d    = (idx_d != 9'd0);
                w_addr_d = DST_BASE + 16'(idx_d) - 16'd1;
                w_data_d = rdata_d;
            end
            StFlush: begin
                busy_d   = 1'b1;
                done_d   = 1'b1;
                wen_d    = 1'b1;
                w_addr_d = FlushAddr;
                w_data_d = rdata_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            page_q       <= '0;
            rdata_q      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            mem_wen_o    <= 1'b0;
            mem_r_addr_o <= '0;
            mem_w_addr_o <= '0;
            mem_w_data_o <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            page_q       <= page_d;
            rdata_q      <= rdata_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            mem_wen_o    <= wen_d;
            mem_r_addr_o <= r_addr_d;
            mem_w_addr_o <= w_addr_d;
            mem_w_data_o <= w_data_d;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: two instances (LEN=160 and LEN=1), each with its own 64 KiB
// memory. A transfer-timeline model predicts every output on every cycle; directed
// scenarios add literal memory and pulse-count expectations.
module tb_oam_dma;
    import sm83_pkg::*;

    localparam int unsigned LEN0 = 160;
    localparam int unsigned LEN1 = 1;
    localparam logic [15:0] DST  = 16'hFE00;

    logic        clk;
    logic        rst;
    logic        st [2];
    logic [7:0]  pg [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic        wen_w [2];
    logic [15:0] ra_w [2];
    logic [15:0] wa_w [2];
    logic [7:0]  wd_w [2];
    logic [7:0]  rd_w [2];
    logic [7:0]  mem [2][65536];

    assign rd_w[0] = mem[0][ra_w[0]];
    assign rd_w[1] = mem[1][ra_w[1]];

    oam_dma #(.LEN(LEN0), .DST_BASE(DST)) u_dut0 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (st[0]),
        .src_page_i   (pg[0]),
        .busy_o       (busy_w[0]),
        .done_o       (done_w[0]),
        .mem_r_addr_o (ra_w[0]),
        .mem_r_data_i (rd_w[0]),
        .mem_wen_o    (wen_w[0]),
        .mem_w_addr_o (wa_w[0]),
        .mem_w_data_o (wd_w[0])
    );

    oam_dma #(.LEN(LEN1), .DST_BASE(DST)) u_dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (st[1]),
        .src_page_i   (pg[1]),
        .busy_o       (busy_w[1]),
        .done_o       (done_w[1]),
        .mem_r_addr_o (ra_w[1]),
        .mem_r_data_i (rd_w[1]),
        .mem_wen_o    (wen_w[1]),
        .mem_w_addr_o (wa_w[1]),
        .mem_w_data_o (wd_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: a transfer is a timeline t = 0 (delay), 1..L (read byte t-1, write byte t-2),
    // L+1 (write last byte, done).
    logic        m_act [2];
    int unsigned m_t [2];
    logic [7:0]  m_page [2];
    logic [7:0]  m_last [2];
    logic [7:0]  m_snap [2][256];
    int unsigned m_len [2];

    int unsigned pass_cnt, chk_cnt;
    int unsigned busy_cnt [2];
    int unsigned done_cnt [2];
    int unsigned wen_cnt [2];
    int unsigned done_at [2];
    logic [15:0] done_wa [2];
    int unsigned wen_bad;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    function automatic logic [7:0] pat(input int kind, input logic [15:0] a);
        case (kind)
            0:       return a[7:0] ^ 8'h5A;
            1:       return a[7:0] ^ 8'hA5;
            2:       return 8'h00;
            3:       return a[7:0] * 8'd3 + 8'd1;
            4:       return 8'hA7;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic fill(input int n, input logic [15:0] base, input int cnt, input int kind);
        for (int i = 0; i < cnt; i++) mem[n][base + 16'(i)] = pat(kind, base + 16'(i));
    endtask

    task automatic region(input string name, input int n, input logic [15:0] dst,
                          input logic [15:0] src, input int cnt, input int kind);
        int bad;
        bad = 0;
        for (int i = 0; i < cnt; i++)
            if (mem[n][dst + 16'(i)] !== pat(kind, src + 16'(i))) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    // Called at a falling edge: samples inputs and pending writes, advances one rising
    // edge, applies the memory write, steps the model and compares every output.
    task automatic cycle();
        logic        we [2];
        logic [15:0] wa [2];
        logic [7:0]  wd [2];
        logic        s [2];
        logic [7:0]  p [2];
        logic        r;
        logic        e_busy, e_done, e_wen;
        logic [15:0] e_ra, e_wa;
        logic [7:0]  e_wd;
        int unsigned i;
        r = rst;
        for (int n = 0; n < 2; n++) begin
            we[n] = wen_w[n];
            wa[n] = wa_w[n];
            wd[n] = wd_w[n];
            s[n]  = st[n];
            p[n]  = pg[n];
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (we[n] === 1'b1) mem[n][wa[n]] = wd[n];
            if (r) begin
                m_act[n]  = 1'b0;
                m_t[n]    = 0;
                m_last[n] = 8'h00;
                m_page[n] = 8'h00;
            end else begin
                if (m_act[n] && m_t[n] >= 1 && m_t[n] <= m_len[n])
                    m_last[n] = m_snap[n][m_t[n] - 1];
                if (s[n]) begin
                    m_act[n]  = 1'b1;
                    m_t[n]    = 0;
                    m_page[n] = p[n];
                    for (int k = 0; k < int'(m_len[n]); k++)
                        m_snap[n][k] = mem[n][{p[n], 8'h00} + 16'(k)];
                end else if (m_act[n]) begin
                    if (m_t[n] == m_len[n] + 1) m_act[n] = 1'b0;
                    else m_t[n]++;
                end
            end
            e_busy = 1'b0; e_done = 1'b0; e_wen = 1'b0;
            e_ra = 16'h0; e_wa = 16'h0; e_wd = 8'h00;
            if (m_act[n]) begin
                e_busy = 1'b1;
                if (m_t[n] >= 1 && m_t[n] <= m_len[n]) begin
                    i    = m_t[n] - 1;
                    e_ra = {m_page[n], 8'h00} + 16'(i);
                    e_wen = (i != 0);
                    e_wa = DST + 16'(i) - 16'd1;
                    e_wd = m_last[n];
                end else if (m_t[n] == m_len[n] + 1) begin
                    e_wen  = 1'b1;
                    e_done = 1'b1;
                    e_wa   = DST + 16'(m_len[n] - 1);
                    e_wd   = m_last[n];
                end
            end
            chk($sformatf("d%0d busy t=%0t", n, $time), 32'(busy_w[n]), 32'(e_busy));
            chk($sformatf("d%0d done t=%0t", n, $time), 32'(done_w[n]), 32'(e_done));
            chk($sformatf("d%0d wen t=%0t", n, $time), 32'(wen_w[n]), 32'(e_wen));
            chk($sformatf("d%0d r_addr t=%0t", n, $time), 32'(ra_w[n]), 32'(e_ra));
            chk($sformatf("d%0d w_addr t=%0t", n, $time), 32'(wa_w[n]), 32'(e_wa));
            chk($sformatf("d%0d w_data t=%0t", n, $time), 32'(wd_w[n]), 32'(e_wd));
            if (busy_w[n] === 1'b1) busy_cnt[n]++;
            if (wen_w[n] === 1'b1) begin
                wen_cnt[n]++;
                if (!m_act[n] || m_t[n] == 0) wen_bad++;
            end
            if (done_w[n] === 1'b1) begin
                done_cnt[n]++;
                done_wa[n] = wa_w[n];
                done_at[n] = busy_cnt[n];
            end
        end
        @(negedge clk);
    endtask

    int unsigned b0, b1, d0, d1, w1;

    task automatic snap_counters();
        b0 = busy_cnt[0]; b1 = busy_cnt[1];
        d0 = done_cnt[0]; d1 = done_cnt[1];
        w1 = wen_cnt[1];
    endtask

    initial begin
        pass_cnt = 0; chk_cnt = 0; wen_bad = 0;
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            st[n] = 1'b0; pg[n] = 8'h00;
            m_act[n] = 1'b0; m_t[n] = 0; m_page[n] = 8'h00; m_last[n] = 8'h00;
            busy_cnt[n] = 0; done_cnt[n] = 0; wen_cnt[n] = 0; done_at[n] = 0;
            done_wa[n] = 16'h0;
        end
        m_len[0] = LEN0;
        m_len[1] = LEN1;
        for (int n = 0; n < 2; n++)
            for (int a = 0; a < 65536; a++) mem[n][a] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst busy", 32'(busy_w[0]), 32'd0);
        chk("rst done", 32'(done_w[0]), 32'd0);
        chk("rst wen", 32'(wen_w[0]), 32'd0);
        chk("rst r_addr", 32'(ra_w[0]), 32'd0);
        chk("rst w_addr", 32'(wa_w[0]), 32'd0);
        chk("rst w_data", 32'(wd_w[0]), 32'd0);
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Full 160-byte copy on dut0, single-byte copy on dut1.
        fill(0, 16'hC000, 160, 0);
        fill(0, 16'hFE00, 161, 5);
        fill(1, 16'h8000, 1, 4);
        fill(1, 16'hFE00, 2, 5);
        snap_counters();
        st[0] = 1'b1; pg[0] = 8'hC0;
        st[1] = 1'b1; pg[1] = 8'h80;
        cycle();
        st[0] = 1'b0; st[1] = 1'b0;
        pg[0] = 8'h33; pg[1] = 8'h44;  // changes while busy are ignored
        repeat (170) cycle();
        chk("A busy cycles", 32'(busy_cnt[0] - b0), 32'd162);
        chk("A done pulses", 32'(done_cnt[0] - d0), 32'd1);
        chk("A done w_addr", 32'(done_wa[0]), 32'hFE9F);
        chk("A done busy idx", 32'(done_at[0] - b0), 32'd162);
        region("A copy", 0, 16'hFE00, 16'hC000, 160, 0);
        chk("A fe00", 32'(mem[0][16'hFE00]), 32'h5A);
        chk("A fe9f", 32'(mem[0][16'hFE9F]), 32'hC5);
        chk("A fea0 untouched", 32'(mem[0][16'hFEA0]), 32'hFF);
        chk("L1 busy cycles", 32'(busy_cnt[1] - b1), 32'd3);
        chk("L1 writes", 32'(wen_cnt[1] - w1), 32'd1);
        chk("L1 done busy idx", 32'(done_at[1] - b1), 32'd3);
        chk("L1 fe00", 32'(mem[1][16'hFE00]), 32'hA7);
        chk("L1 fe01 untouched", 32'(mem[1][16'hFE01]), 32'hFF);

        // Restart with page D0 during XFER idx 50 of a C0 transfer.
        fill(0, 16'hFE00, 160, 2);
        fill(0, 16'hD000, 160, 1);
        snap_counters();
        st[0] = 1'b1; pg[0] = 8'hC0;
        cycle();
        st[0] = 1'b0;
        repeat (51) cycle();
        st[0] = 1'b1; pg[0] = 8'hD0;
        cycle();
        st[0] = 1'b0;
        region("B partial C0", 0, 16'hFE00, 16'hC000, 49, 0);
        repeat (170) cycle();
        chk("B busy cycles", 32'(busy_cnt[0] - b0), 32'd214);
        chk("B done pulses", 32'(done_cnt[0] - d0), 32'd1);
        region("B D0 copy", 0, 16'hFE00, 16'hD000, 160, 1);

        // Reset during XFER idx 20.
        fill(0, 16'hFE00, 160, 2);
        st[0] = 1'b1; pg[0] = 8'hC0;
        cycle();
        st[0] = 1'b0;
        repeat (21) cycle();
        chk("C busy before rst", 32'(busy_w[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("C rst busy", 32'(busy_w[0]), 32'd0);
        chk("C rst wen", 32'(wen_w[0]), 32'd0);
        chk("C rst r_addr", 32'(ra_w[0]), 32'd0);
        chk("C rst w_addr", 32'(wa_w[0]), 32'd0);
        chk("C rst w_data", 32'(wd_w[0]), 32'd0);
        chk("C rst done", 32'(done_w[0]), 32'd0);
        cycle();
        rst = 1'b0;
        repeat (5) cycle();
        region("C written", 0, 16'hFE00, 16'hC000, 19, 0);
        chk("C fe12", 32'(mem[0][16'hFE12]), 32'h48);
        chk("C fe13", 32'(mem[0][16'hFE13]), 32'h00);
        region("C untouched", 0, 16'hFE13, 16'hFE13, 141, 2);

        // Source overlaps destination.
        fill(0, 16'hFE00, 160, 3);
        st[0] = 1'b1; pg[0] = 8'hFE;
        cycle();
        st[0] = 1'b0;
        repeat (170) cycle();
        region("D overlap", 0, 16'hFE00, 16'hFE00, 160, 3);

        // start held for two cycles: one transfer, restarted once from DELAY.
        fill(0, 16'hFE00, 160, 2);
        snap_counters();
        st[0] = 1'b1; pg[0] = 8'hC0;
        cycle();
        cycle();
        st[0] = 1'b0;
        repeat (170) cycle();
        chk("E busy cycles", 32'(busy_cnt[0] - b0), 32'd163);
        chk("E done pulses", 32'(done_cnt[0] - d0), 32'd1);
        region("E copy", 0, 16'hFE00, 16'hC000, 160, 0);
        chk("wen in idle/delay", 32'(wen_bad), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
